decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  Instruction decode stage of the single-cycle MIPS datapath; consumes fetch's instruction/pc4.
//  Holds the 32x32 register file, decodes control, extends immediates, and resolves beq/j.
//  Returns branch_addr/do_branch to fetch in the same cycle; feeds ALU/memory/writeback.
// PARAMETERS
//  DATA_W     32  register/data width (only 32 is supported)
//  NREGS      32  register count; $0 hardwired to zero
// PORTS
//  clock        in   1   rising-edge clock, single clock domain
//  reset        in   1   synchronous, ACTIVE-LOW reset (sampled on clock rising edge)
//  instruction  in   32  current instruction from fetch
//  pc4          in   32  pc+4 from fetch
//  wb_en        in   1   writeback enable
//  wb_addr      in   5   writeback register index
//  wb_data      in   32  writeback data
//  rs_data      out  32  register[instr[25:21]]
//  rt_data      out  32  register[instr[20:16]]
//  imm_ext      out  32  extended immediate (see behaviour)
//  dest_reg     out  5   rd (R-type) or rt (lw/ori/lui)
//  alu_op       out  3   000 add,001 sub,010 and,011 or,100 slt,101 lui
//  alu_src      out  1   1 = ALU B operand is imm_ext
//  mem_read     out  1   lw
//  mem_write    out  1   sw
//  mem_to_reg   out  1   writeback selects memory data
//  reg_write    out  1   instruction writes dest_reg
//  branch_addr  out  32  redirect target to fetch
//  do_branch    out  1   redirect fetch this cycle
//  illegal      out  1   unsupported opcode/funct
// BEHAVIOUR
//  - Regfile write: on rising clock when reset=1, wb_en=1, wb_addr!=0 -> reg[wb_addr]<=wb_data.
//  - Writes to $0 ignored; rs/rt index 0 always reads 0.
//  - Reads are combinational, no write bypass: a write is visible from the next cycle
//    (avoids comb loop rs_data->ALU->wb_data).
//  - Reset (reset=0 at rising edge): all registers cleared to 0 in that one cycle.
//  - While reset=0: reg_write, mem_write, mem_read, do_branch, illegal forced 0; other outputs
//    free-running decode. Writeback is ignored while reset=0, even mid-sequence.
//  - Decode (opcode instr[31:26], funct instr[5:0]):
//    op 00 funct 20/22/24/25/2A: add/sub/and/or/slt; reg_write=1, dest=rd, alu_src=0.
//    instr==0 (nop): all enables 0, illegal=0.
//    op 23 lw: add, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, dest=rt.
//    op 2B sw: add, alu_src=1, mem_write=1.
//    op 0D ori: or, alu_src=1, reg_write=1, dest=rt, imm_ext zero-extended.
//    op 0F lui: alu_op=101, alu_src=1, reg_write=1, dest=rt, imm_ext={imm,16'h0}.
//    op 04 beq: sub, do_branch=(rs_data==rt_data).
//    op 02 j: do_branch=1.
//    any other op/funct: illegal=1, all enables 0, do_branch=0.
//  - imm_ext sign-extended from instr[15:0] except ori/lui as above.
//  - branch_addr: beq = pc4 + (sext(imm)<<2), 32-bit wrap, no overflow flag;
//    j = {pc4[31:28], instr[25:0], 2'b00}; otherwise pc4.
//  - Latency: all outputs combinational in the same cycle as instruction; regfile state is
//    the only sequential element.
//  - Simultaneous write to rs index and read of rs: old value read this cycle.
// TESTING
//  1 reset=0 one edge after writes -> every reg reads 0; wb_en=1 during reset -> no write.
//  2 wb_en=1, wb_addr=3, wb_data=32'hDEADBEEF -> rs_data same cycle old; next cycle
//    instr 0x00600020 gives rs_data=DEADBEEF.
//  3 wb_addr=0, wb_data=5 -> $0 still reads 0.
//  4 $5=$1=7, pc4=0x1C, instr 0x10a1fff9 -> do_branch=1, branch_addr=0x00000000;
//    set $5=8 -> do_branch=0.
//  5 instr 0x08000001, pc4=0x10 -> do_branch=1, branch_addr=0x00000004.
//  6 instr 0x3C090004 -> alu_op=101, imm_ext=0x00040000, dest=9;
//    0xFC000000 -> illegal=1, reg_write=0.

Source files
------------

// File: rtl/decode.sv
// Decode stage of the single-cycle MIPS datapath: register file, control decode,
// immediate extension and beq/j target resolution, all combinational except the regfile.
module decode #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc4,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [31:0]       imm_ext,
  output logic [4:0]        dest_reg,
  output logic [2:0]        alu_op,
  output logic              alu_src,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic [31:0]       branch_addr,
  output logic              do_branch,
  output logic              illegal
);

  localparam int unsigned AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [AW-1:0] rs_idx;
  logic [AW-1:0] rt_idx;
  logic [AW-1:0] rd_idx;
  logic [15:0]   imm;
  logic [31:0]   sext_imm;

  logic reg_write_dec;
  logic mem_read_dec;
  logic mem_write_dec;
  logic do_branch_dec;
  logic illegal_dec;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign rs_idx   = instruction[25:21];
  assign rt_idx   = instruction[20:16];
  assign rd_idx   = instruction[15:11];
  assign imm      = instruction[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};

  // Writeback; $0 is never stored so it stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != '0)) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a same-cycle write is only seen from the next cycle.
  assign rs_data = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_data = (rt_idx == '0) ? '0 : regs_q[rt_idx];

  always_comb begin
    alu_op        = ALU_ADD;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    dest_reg      = rd_idx;
    imm_ext       = sext_imm;
    branch_addr   = pc4;
    reg_write_dec = 1'b0;
    mem_read_dec  = 1'b0;
    mem_write_dec = 1'b0;
    do_branch_dec = 1'b0;
    illegal_dec   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        if (instruction != '0) begin
          reg_write_dec = 1'b1;
          unique case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: begin
              reg_write_dec = 1'b0;
              illegal_dec   = 1'b1;
            end
          endcase
        end
      end
      OP_LW: begin
        alu_src       = 1'b1;
        mem_read_dec  = 1'b1;
        mem_to_reg    = 1'b1;
        reg_write_dec = 1'b1;
        dest_reg      = rt_idx;
      end
      OP_SW: begin
        alu_src       = 1'b1;
        mem_write_dec = 1'b1;
      end
      OP_ORI: begin
        alu_op        = ALU_OR;
        alu_src       = 1'b1;
        reg_write_dec = 1'b1;
        dest_reg      = rt_idx;
        imm_ext       = {16'h0, imm};
      end
      OP_LUI: begin
        alu_op        = ALU_LUI;
        alu_src       = 1'b1;
        reg_write_dec = 1'b1;
        dest_reg      = rt_idx;
        imm_ext       = {imm, 16'h0};
      end
      OP_BEQ: begin
        alu_op        = ALU_SUB;
        do_branch_dec = (rs_data == rt_data);
        branch_addr   = pc4 + {sext_imm[29:0], 2'b00};
      end
      OP_J: begin
        do_branch_dec = 1'b1;
        branch_addr   = {pc4[31:28], instruction[25:0], 2'b00};
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  // Side-effecting controls are suppressed while reset is held.
  assign reg_write = reset & reg_write_dec;
  assign mem_read  = reset & mem_read_dec;
  assign mem_write = reset & mem_write_dec;
  assign do_branch = reset & do_branch_dec;
  assign illegal   = reset & illegal_dec;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed cases followed by random instructions/writebacks
// compared against a mnemonic-level model of the register file and decoder.
module tb_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest_reg;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] branch_addr;
  logic        do_branch;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  logic [31:0] mregs [32];

  decode dut (
    .clock(clock), .reset(reset), .instruction(instruction), .pc4(pc4),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .dest_reg(dest_reg),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch_addr(branch_addr),
    .do_branch(do_branch), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic string kind_of(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'h0) return "nop";
    if (op == 6'h00) begin
      if (fn == 6'h20) return "add";
      if (fn == 6'h22) return "sub";
      if (fn == 6'h24) return "and";
      if (fn == 6'h25) return "or";
      if (fn == 6'h2A) return "slt";
      return "ill";
    end
    if (op == 6'h23) return "lw";
    if (op == 6'h2B) return "sw";
    if (op == 6'h0D) return "ori";
    if (op == 6'h0F) return "lui";
    if (op == 6'h04) return "beq";
    if (op == 6'h02) return "j";
    return "ill";
  endfunction

  // Compare every defined output against the mnemonic-level expectation.
  task automatic model_check();
    string       k;
    logic [31:0] ers, ert, sx, eimm, ebr;
    logic        rtype, writes, on;
    int          aop;
    k      = kind_of(instruction);
    on     = reset;
    ers    = mregs[instruction[25:21]];
    ert    = mregs[instruction[20:16]];
    sx     = 32'($signed(instruction[15:0]));
    rtype  = (k == "add") || (k == "sub") || (k == "and") || (k == "or") || (k == "slt");
    writes = rtype || (k == "lw") || (k == "ori") || (k == "lui");
    eimm   = sx;
    if (k == "ori") eimm = 32'(instruction[15:0]);
    if (k == "lui") eimm = 32'(instruction[15:0]) * 32'd65536;
    ebr = pc4;
    if (k == "beq") ebr = pc4 + sx * 32'd4;
    if (k == "j")   ebr = (pc4 & 32'hF000_0000) | ((instruction & 32'h03FF_FFFF) << 2);
    chk({k, "/rs_data"}, rs_data, ers);
    chk({k, "/rt_data"}, rt_data, ert);
    chk({k, "/imm_ext"}, imm_ext, eimm);
    chk({k, "/branch_addr"}, branch_addr, ebr);
    chk({k, "/do_branch"}, 32'(do_branch), 32'(on && ((k == "j") || (k == "beq" && ers == ert))));
    chk({k, "/reg_write"}, 32'(reg_write), 32'(on && writes));
    chk({k, "/mem_read"}, 32'(mem_read), 32'(on && (k == "lw")));
    chk({k, "/mem_write"}, 32'(mem_write), 32'(on && (k == "sw")));
    chk({k, "/illegal"}, 32'(illegal), 32'(on && (k == "ill")));
    aop = -1;
    if (k == "add" || k == "lw" || k == "sw") aop = 0;
    if (k == "sub" || k == "beq") aop = 1;
    if (k == "and") aop = 2;
    if (k == "or" || k == "ori") aop = 3;
    if (k == "slt") aop = 4;
    if (k == "lui") aop = 5;
    if (aop >= 0) chk({k, "/alu_op"}, 32'(alu_op), 32'(aop));
    if (rtype) chk({k, "/alu_src"}, 32'(alu_src), 32'd0);
    if (k == "lw" || k == "sw" || k == "ori" || k == "lui") chk({k, "/alu_src"}, 32'(alu_src), 32'd1);
    if (rtype) chk({k, "/dest_reg"}, 32'(dest_reg), 32'(instruction[15:11]));
    if (k == "lw" || k == "ori" || k == "lui") chk({k, "/dest_reg"}, 32'(dest_reg), 32'(instruction[20:16]));
    if (writes) chk({k, "/mem_to_reg"}, 32'(mem_to_reg), 32'(k == "lw"));
  endtask

  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] p,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clock);
    reset       = r;
    instruction = ins;
    pc4         = p;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    #1;
    model_check();
  endtask

  // Model register file update at the edge that ends the current step.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else if (wb_en && wb_addr != 5'd0) begin
      mregs[wb_addr] = wb_data;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    logic [5:0]  fns [5];
    logic [5:0]  bad_ops [5];
    int          t;
    fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad_ops = '{6'h01, 6'h05, 6'h08, 6'h3F, 6'h2A};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    if ($urandom_range(0, 2) == 0) rt = rs;
    t = int'($urandom_range(0, 12));
    if (t <= 4) return {6'h00, rs, rt, rd, 5'd0, fns[t]};
    if (t == 5) return {6'h23, rs, rt, im};
    if (t == 6) return {6'h2B, rs, rt, im};
    if (t == 7) return {6'h0D, rs, rt, im};
    if (t == 8) return {6'h0F, 5'd0, rt, im};
    if (t == 9) return {6'h04, rs, rt, im};
    if (t == 10) return {6'h02, 26'($urandom)};
    if (t == 11) return {bad_ops[$urandom_range(0, 4)], rs, rt, im};
    if ($urandom_range(0, 1) == 0) return 32'h0;
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  initial begin
    reset = 1'b0; instruction = 32'h0; pc4 = 32'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    repeat (2) @(posedge clock);

    // Populate, then reset with a writeback pending; everything must read zero.
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 32'h0, 32'h4, 1'b1, 5'(i), 32'h1000 + 32'(i));
      tick();
    end
    drive(1'b0, 32'h0022_1820, 32'h4, 1'b1, 5'd2, 32'h55);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, {6'h00, 5'(i), 5'(31 - i), 5'd0, 5'd0, 6'h20}, 32'h4, 1'b0, 5'd0, 32'h0);
      chk("post_rst_rs", rs_data, 32'h0);
      chk("post_rst_rt", rt_data, 32'h0);
      tick();
    end

    // Write not visible until the following cycle.
    drive(1'b1, 32'h0060_0020, 32'h8, 1'b1, 5'd3, 32'hDEAD_BEEF);
    chk("wr_old_rs", rs_data, 32'h0);
    tick();
    drive(1'b1, 32'h0060_0020, 32'h8, 1'b0, 5'd0, 32'h0);
    chk("wr_new_rs", rs_data, 32'hDEAD_BEEF);
    tick();

    drive(1'b1, 32'h0, 32'h8, 1'b1, 5'd0, 32'h5);
    tick();
    drive(1'b1, 32'h0000_0020, 32'h8, 1'b0, 5'd0, 32'h0);
    chk("zero_reg", rs_data, 32'h0);
    tick();

    // beq backward to address 0, then operands made unequal.
    drive(1'b1, 32'h0, 32'h8, 1'b1, 5'd5, 32'd7);
    tick();
    drive(1'b1, 32'h0, 32'h8, 1'b1, 5'd1, 32'd7);
    tick();
    drive(1'b1, 32'h10a1_fff9, 32'h1C, 1'b1, 5'd5, 32'd8);
    chk("beq_taken", 32'(do_branch), 32'd1);
    chk("beq_target", branch_addr, 32'h0);
    tick();
    drive(1'b1, 32'h10a1_fff9, 32'h1C, 1'b0, 5'd0, 32'h0);
    chk("beq_not_taken", 32'(do_branch), 32'd0);
    tick();

    drive(1'b1, 32'h0800_0001, 32'h10, 1'b0, 5'd0, 32'h0);
    chk("j_taken", 32'(do_branch), 32'd1);
    chk("j_target", branch_addr, 32'h4);
    tick();

    drive(1'b1, 32'h3C09_0004, 32'h14, 1'b0, 5'd0, 32'h0);
    chk("lui_alu_op", 32'(alu_op), 32'd5);
    chk("lui_imm", imm_ext, 32'h0004_0000);
    chk("lui_dest", 32'(dest_reg), 32'd9);
    tick();
    drive(1'b1, 32'hFC00_0000, 32'h18, 1'b0, 5'd0, 32'h0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_reg_write", 32'(reg_write), 32'd0);
    tick();

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
